// File: rtl/gpio_input_event_unit.sv
// ----------------------------------------------------------------------------
// gpio_input_event_unit
//
// Receive side of the pad-to-GPIO path. Every pad input is brought into the
// clock domain through a synchroniser chain. Each pin can optionally be
// glitch-filtered. Filtering runs off a shared prescaled tick and accepts a
// new value only after FILT_LEN consecutive differing ticks. Per-pin
// edge/level events are derived from the filtered value. They are held in
// sticky write-1-to-clear status bits and ORed into a single interrupt.
//
// Parameters
//   NGPIO        number of GPIO pins
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FILT_LEN     consecutive differing ticks needed to accept a new value (>= 1)
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   pad_i        raw pad inputs, asynchronous to clk_i
//   filt_en_i    per-pin glitch-filter enable
//   prescale_i   filter tick divider, one tick every prescale_i+1 cycles
//   inttype_i    per-pin event type, 2 bits per pin: 00 rise, 01 fall,
//                10 high, 11 low
//   en_i         per-pin event enable (gates new status sets only)
//   clr_i        per-pin write-1-to-clear pulse for status
//   gpio_in_o    synchronised / filtered pin value
//   status_o     sticky event status
//   irq_o        OR of all status bits
// ----------------------------------------------------------------------------
module gpio_input_event_unit #(
    parameter int NGPIO       = 65,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NGPIO-1:0]     pad_i,
    input  logic [NGPIO-1:0]     filt_en_i,
    input  logic [7:0]           prescale_i,
    input  logic [2*NGPIO-1:0]   inttype_i,
    input  logic [NGPIO-1:0]     en_i,
    input  logic [NGPIO-1:0]     clr_i,
    output logic [NGPIO-1:0]     gpio_in_o,
    output logic [NGPIO-1:0]     status_o,
    output logic                 irq_o
);

    localparam int CW = $clog2(FILT_LEN) + 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

    logic [NGPIO-1:0]         sync_q [SYNC_STAGES];
    logic [NGPIO-1:0]         sync_s;
    logic [7:0]               pre_cnt_q;
    logic                     tick;
    logic [NGPIO-1:0]         stable_q;
    logic [NGPIO-1:0]         stable_d;
    logic [NGPIO-1:0][CW-1:0] filt_cnt_q;
    logic [NGPIO-1:0][CW-1:0] filt_cnt_d;
    logic [NGPIO-1:0]         event_hit;
    logic [NGPIO-1:0]         status_q;
    logic [NGPIO-1:0]         status_d;

    // Synchroniser chain: stage 0 samples the raw pads and the last stage is
    // the first value considered safe to use in this clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The tick uses a >= compare rather than ==. If software lowers
    // prescale_i below the running count, the next cycle ticks and the
    // counter restarts instead of wrapping through 255.
    assign tick = (pre_cnt_q >= prescale_i);

    // Free-running prescaler shared by all pin filters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
        end else if (tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + 8'd1;
        end
    end

    // Per-pin glitch filter. An unfiltered pin follows the synchroniser
    // output directly, and its counter is held at zero. That is also why
    // toggling the enable always restarts counting from zero. A filtered pin
    // only moves on ticks. A tick that agrees with the current value
    // restarts the run. FILT_LEN consecutive disagreeing ticks accept the
    // new value.
    always_comb begin
        stable_d   = stable_q;
        filt_cnt_d = filt_cnt_q;
        for (int k = 0; k < NGPIO; k++) begin
            if (!filt_en_i[k]) begin
                stable_d[k]   = sync_s[k];
                filt_cnt_d[k] = '0;
            end else if (tick) begin
                if (sync_s[k] == stable_q[k]) begin
                    filt_cnt_d[k] = '0;
                end else if (filt_cnt_q[k] == FILT_LAST) begin
                    stable_d[k]   = sync_s[k];
                    filt_cnt_d[k] = '0;
                end else begin
                    filt_cnt_d[k] = filt_cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q   <= '0;
            filt_cnt_q <= '0;
        end else begin
            stable_q   <= stable_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Events are taken from the value about to be registered (stable_d)
    // against the current one. This makes status and gpio_in_o change on the
    // same clock edge.
    always_comb begin
        event_hit = '0;
        for (int k = 0; k < NGPIO; k++) begin
            case (inttype_i[2*k +: 2])
                2'b00:   event_hit[k] =  stable_d[k] & ~stable_q[k];
                2'b01:   event_hit[k] = ~stable_d[k] &  stable_q[k];
                2'b10:   event_hit[k] =  stable_d[k];
                default: event_hit[k] = ~stable_d[k];
            endcase
        end
    end

    // Sticky W1C status. The set term is ORed in after the clear, so a new
    // event in the same cycle as a clear wins. A persisting level therefore
    // re-asserts the bit immediately.
    assign status_d = (status_q & ~clr_i) | (event_hit & en_i);

    // Status register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // The interrupt is a pure OR of registered status, so it cannot glitch
    // on input activity.
    assign gpio_in_o = stable_q;
    assign status_o  = status_q;
    assign irq_o     = |status_q;

endmodule

// File: tb/tb_gpio_input_event_unit.sv
// ----------------------------------------------------------------------------
// tb_gpio_input_event_unit
//
// Self-checking bench for gpio_input_event_unit. Each scenario task queues
// its expected per-cycle pin results when it schedules the stimulus. It then
// steps the clock and pops and compares each expectation once its cycle has
// been reached. Cycle n means the value seen just after the n-th rising edge
// following the stimulus start (a falling edge).
// ----------------------------------------------------------------------------
module tb_gpio_input_event_unit;

    localparam int NGPIO       = 65;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NGPIO-1:0]     pad;
    logic [NGPIO-1:0]     filt_en;
    logic [7:0]           prescale;
    logic [2*NGPIO-1:0]   inttype;
    logic [NGPIO-1:0]     en;
    logic [NGPIO-1:0]     clr;
    logic [NGPIO-1:0]     gpio_in;
    logic [NGPIO-1:0]     status;
    logic                 irq;

    typedef struct {
        int   cyc;
        int   pin;
        logic gpio;
        logic stat;
        logic irq;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  e;
    int    checks = 0;
    int    errors = 0;
    int    cyc;
    string tname;

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    gpio_input_event_unit #(
        .NGPIO       (NGPIO),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pad_i      (pad),
        .filt_en_i  (filt_en),
        .prescale_i (prescale),
        .inttype_i  (inttype),
        .en_i       (en),
        .clr_i      (clr),
        .gpio_in_o  (gpio_in),
        .status_o   (status),
        .irq_o      (irq)
    );

    function automatic void push_exp(int c, int p, logic g, logic s, logic i);
        exp_t t;
        t.cyc  = c;
        t.pin  = p;
        t.gpio = g;
        t.stat = s;
        t.irq  = i;
        exp_q.push_back(t);
    endfunction

    // Bring every pin to a known idle state with all status cleared.
    task automatic quiet();
        @(negedge clk);
        pad      = '0;
        filt_en  = '0;
        prescale = '0;
        inttype  = '0;
        en       = '0;
        clr      = '0;
        repeat (5) @(negedge clk);
        clr = '1;
        @(negedge clk);
        clr = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        tname    = "reset";
        rst      = 1'b1;
        pad      = '1;
        filt_en  = '0;
        prescale = '0;
        inttype  = '0;
        en       = '1;
        clr      = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (gpio_in !== '0) begin
            errors++;
            $display("[TB] FAIL %s gpio_in got=%h exp=0", tname, gpio_in);
        end
        checks++;
        if (status !== '0) begin
            errors++;
            $display("[TB] FAIL %s status got=%h exp=0", tname, status);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s irq got=%b exp=0", tname, irq);
        end
        pad = '0;
        en  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rise_clear();
        tname = "rise_clear";
        quiet();
        inttype[11:10] = 2'b00;
        en[5]          = 1'b1;
        pad[5]         = 1'b1;
        push_exp(1, 5, 0, 0, 0);
        push_exp(2, 5, 0, 0, 0);
        push_exp(3, 5, 1, 1, 1);
        push_exp(4, 5, 1, 1, 1);
        push_exp(5, 5, 1, 0, 0);
        push_exp(6, 5, 1, 0, 0);
        for (cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            clr[5] = (cyc == 4);
        end
    endtask

    task automatic test_filter_pulse();
        tname = "filter_pulse";
        quiet();
        filt_en[0]   = 1'b1;
        inttype[1:0] = 2'b00;
        en[0]        = 1'b1;
        // A two-cycle pulse must be rejected.
        pad[0] = 1'b1;
        for (int c = 1; c <= 8; c++) push_exp(c, 0, 0, 0, 0);
        for (cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s short gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s short status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s short irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            if (cyc == 2) pad[0] = 1'b0;
        end
        // A three-cycle pulse is accepted, then its trailing edge is accepted too.
        pad[0] = 1'b1;
        for (int c = 1; c <= 4; c++) push_exp(c, 0, 0, 0, 0);
        for (int c = 5; c <= 7; c++) push_exp(c, 0, 1, 1, 1);
        push_exp(8, 0, 0, 1, 1);
        push_exp(9, 0, 0, 1, 1);
        for (cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s long gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s long status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s long irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            if (cyc == 3) pad[0] = 1'b0;
        end
    endtask

    task automatic test_level_set_wins();
        tname = "level_set_wins";
        quiet();
        inttype[129:128] = 2'b11;
        en[64]           = 1'b1;
        push_exp(1, 64, 0, 1, 1);
        push_exp(2, 64, 0, 1, 1);
        push_exp(3, 64, 0, 1, 1);
        push_exp(4, 64, 0, 1, 1);
        push_exp(5, 64, 0, 1, 1);
        push_exp(6, 64, 1, 1, 1);
        push_exp(7, 64, 1, 0, 0);
        push_exp(8, 64, 1, 0, 0);
        push_exp(9, 64, 1, 0, 0);
        for (cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            clr[64] = (cyc == 2) || (cyc == 6);
            if (cyc == 3) pad[64] = 1'b1;
        end
    endtask

    task automatic test_enable_gating();
        tname = "enable_gating";
        quiet();
        inttype[15:14] = 2'b01;
        en[7]          = 1'b0;
        pad[7]         = 1'b1;
        push_exp(1, 7, 0, 0, 0);
        push_exp(2, 7, 0, 0, 0);
        for (int c = 3; c <= 6; c++) push_exp(c, 7, 1, 0, 0);
        for (int c = 7; c <= 12; c++) push_exp(c, 7, 0, 0, 0);
        for (int c = 13; c <= 16; c++) push_exp(c, 7, 1, 0, 0);
        push_exp(17, 7, 0, 1, 1);
        push_exp(18, 7, 0, 1, 1);
        for (cyc = 1; cyc <= 18; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            if (cyc == 4)  pad[7] = 1'b0;
            if (cyc == 8)  en[7]  = 1'b1;
            if (cyc == 10) pad[7] = 1'b1;
            if (cyc == 14) pad[7] = 1'b0;
        end
    endtask

    task automatic test_prescale();
        tname = "prescale";
        @(negedge clk);
        rst        = 1'b1;
        pad        = '0;
        filt_en    = '0;
        filt_en[3] = 1'b1;
        prescale   = 8'd3;
        inttype    = '0;
        inttype[7:6] = 2'b01;
        en         = '0;
        en[3]      = 1'b1;
        clr        = '0;
        exp_q.delete();
        @(negedge clk);
        // The prescaler restarts at 0, so ticks land on cycles 4, 8, 12, ...
        rst    = 1'b0;
        pad[3] = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            push_exp(c, 3, (c >= 12 && c <= 21), (c >= 22), (c >= 22));
        end
        for (cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            @(negedge clk);
            if (cyc == 12) pad[3]   = 1'b0;
            if (cyc == 21) prescale = 8'd0;
        end
    endtask

    task automatic test_async_reset();
        tname = "async_reset";
        // Start a new filter run on pin 3 while its fall status is still pending.
        pad[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s pre_irq got=%b exp=1", tname, irq);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (gpio_in !== '0) begin
            errors++;
            $display("[TB] FAIL %s gpio_in got=%h exp=0", tname, gpio_in);
        end
        checks++;
        if (status !== '0) begin
            errors++;
            $display("[TB] FAIL %s status got=%h exp=0", tname, status);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s irq got=%b exp=0", tname, irq);
        end
        @(negedge clk);
        filt_en  = '0;
        prescale = '0;
        inttype  = '0;
        en       = '0;
        en[2]    = 1'b1;
        clr      = '0;
        pad      = '0;
        pad[2]   = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_exp(1, 2, 0, 0, 0);
        push_exp(2, 2, 0, 0, 0);
        push_exp(3, 2, 1, 1, 1);
        push_exp(4, 2, 1, 1, 1);
        for (cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (gpio_in[e.pin] !== e.gpio) begin
                    errors++;
                    $display("[TB] FAIL %s gpio_in[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, gpio_in[e.pin], e.gpio);
                end
                checks++;
                if (status[e.pin] !== e.stat) begin
                    errors++;
                    $display("[TB] FAIL %s status[%0d] cyc=%0d got=%b exp=%b", tname, e.pin, cyc, status[e.pin], e.stat);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("[TB] FAIL %s irq cyc=%0d got=%b exp=%b", tname, cyc, irq, e.irq);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (status !== 65'd4) begin
                    errors++;
                    $display("[TB] FAIL %s status_vec got=%h exp=%h", tname, status, 65'd4);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rise_clear();
        test_filter_pulse();
        test_level_set_wins();
        test_enable_gating();
        test_prescale();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
